// File: rtl/board_uart_dump.sv
// board_uart_dump
// ---------------------------------------------------------------------------
// Walks the 8x8 game board through the controller's read port and sends it
// as ASCII text on an 8N1 serial line. Rows go from 7 (top) down to 0, and
// columns go from 0 to 7. Each row becomes 8 cell characters followed by
// CR LF, so one frame is 80 characters.
//
// Ports
//   clk          in   system clock, posedge
//   rst          in   asynchronous active-high reset
//   start        in   one-cycle frame request, ignored while busy
//   read_row     out  [2:0] board row address (0 = bottom)
//   read_col     out  [2:0] board column address
//   data_in      in   [1:0] cell content at the addressed row/col
//   winning_in   in   addressed cell belongs to the winning line
//   busy         out  frame in progress
//   done         out  one-cycle pulse after the final stop bit
//   tx           out  serial line, idle high
//   dbg_state_o  out  [1:0] current FSM state (IDLE/FETCH/SEND/NEXT)
//
// Request handshake: start is a single-cycle request with no ready.
//   - It is taken only in IDLE and only when done is low.
//   - busy rises in the cycle after the request is taken.
//   - A request that arrives while busy is high, or in the done cycle, is
//     dropped. It is not queued.
// ---------------------------------------------------------------------------
module board_uart_dump #(
  parameter int CLKS_PER_BIT = 87,
  parameter int READ_LAT     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] read_row,
  output logic [2:0] read_col,
  input  logic [1:0] data_in,
  input  logic       winning_in,
  output logic       busy,
  output logic       done,
  output logic       tx,
  output logic [1:0] dbg_state_o
);

  localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]      LAT_LAST  = 2'(READ_LAT);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, NEXT} state_t;
  // Kind of the character that was just sent. NEXT uses it to choose what
  // comes after that character.
  typedef enum logic [1:0] {K_CELL, K_CR, K_LF} kind_t;

  state_t        state_q;
  kind_t         kind_q;
  logic [BW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic [1:0]    lat_q;
  logic [8:0]    shift_q;   // remaining data bits with the stop bit on top
  logic [2:0]    row_q;
  logic [2:0]    col_q;
  logic          busy_q;
  logic          done_q;
  logic          tx_q;
  logic [7:0]    cell_char;

  // Maps a cell to its ASCII character. An empty cell ignores winning_in.
  always_comb begin
    cell_char = 8'h3F;
    unique case (data_in)
      2'b00:   cell_char = 8'h2E;
      2'b01:   cell_char = winning_in ? 8'h78 : 8'h58;
      2'b10:   cell_char = winning_in ? 8'h6F : 8'h4F;
      default: cell_char = 8'h3F;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      kind_q  <= K_CELL;
      baud_q  <= '0;
      bit_q   <= '0;
      lat_q   <= '0;
      shift_q <= '1;
      row_q   <= 3'd7;
      col_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // The done cycle still belongs to the frame that just ended.
          if (start && !done_q) begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
            row_q   <= 3'd7;
            col_q   <= 3'd0;
            lat_q   <= 2'd0;
          end
        end
        FETCH: begin
          // The address is already stable in the first FETCH cycle, so data
          // is valid READ_LAT cycles later. That cycle is the last FETCH cycle.
          if (lat_q == LAT_LAST) begin
            shift_q <= {1'b1, cell_char};
            kind_q  <= K_CELL;
            tx_q    <= 1'b0;
            baud_q  <= '0;
            bit_q   <= 4'd0;
            state_q <= SEND;
          end else begin
            lat_q <= lat_q + 2'd1;
          end
        end
        SEND: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == 4'd9) begin
              state_q <= NEXT;  // the stop bit leaves tx high
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= {1'b1, shift_q[8:1]};
              bit_q   <= bit_q + 4'd1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        NEXT: begin
          if (kind_q == K_CELL && col_q != 3'd7) begin
            col_q   <= col_q + 3'd1;
            lat_q   <= 2'd0;
            state_q <= FETCH;
          end else if (kind_q == K_CELL) begin
            shift_q <= {1'b1, 8'h0D};
            kind_q  <= K_CR;
            tx_q    <= 1'b0;
            baud_q  <= '0;
            bit_q   <= 4'd0;
            state_q <= SEND;
          end else if (kind_q == K_CR) begin
            shift_q <= {1'b1, 8'h0A};
            kind_q  <= K_LF;
            tx_q    <= 1'b0;
            baud_q  <= '0;
            bit_q   <= 4'd0;
            state_q <= SEND;
          end else if (row_q != 3'd0) begin
            row_q   <= row_q - 3'd1;
            col_q   <= 3'd0;
            lat_q   <= 2'd0;
            state_q <= FETCH;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read_row    = row_q;
  assign read_col    = col_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign tx          = tx_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_board_uart_dump.sv
// Testbench for board_uart_dump. It models the board memory with one cycle
// of read latency and decodes tx with a serial receiver. Each decoded frame
// is compared with a queue built from the board contents.
module tb_board_uart_dump;

  localparam int CPB = 4;
  localparam int RL  = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] read_row, read_col;
  logic [1:0] data_in;
  logic       winning_in;
  logic       busy, done, tx;
  logic [1:0] dbg_state_o;

  board_uart_dump #(.CLKS_PER_BIT(CPB), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst), .start(start),
    .read_row(read_row), .read_col(read_col),
    .data_in(data_in), .winning_in(winning_in),
    .busy(busy), .done(done), .tx(tx), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- board memory model (READ_LAT = 1) ----------------
  logic [1:0] cell_m [0:7][0:7];
  logic       win_m  [0:7][0:7];
  logic [5:0] addr_d;
  always @(posedge clk) addr_d <= {read_row, read_col};
  assign data_in    = cell_m[addr_d[5:3]][addr_d[2:0]];
  assign winning_in = win_m[addr_d[5:3]][addr_d[2:0]];

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         last_stop_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] char_of(input logic [1:0] d, input logic w);
    if (d == 2'b00) return ".";
    if (d == 2'b01) return w ? "x" : "X";
    if (d == 2'b10) return w ? "o" : "O";
    return "?";
  endfunction

  // Expected frame: top row first, each row ends with CR LF.
  function automatic void build_expected();
    exp_q.delete();
    for (int r = 7; r >= 0; r--) begin
      for (int c = 0; c < 8; c++) exp_q.push_back(char_of(cell_m[r][c], win_m[r][c]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  task automatic clear_board();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        cell_m[r][c] = 2'b00;
        win_m[r][c]  = 1'b0;
      end
  endtask

  // ---------------- serial receiver ----------------
  // A character starts when tx is low while the line is idle. Every bit must
  // keep one value for exactly CPB cycles.
  logic [9:0] mon_bits;
  bit         mon_ok, mon_abort;
  int         mon_t0;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        mon_ok = 1'b1; mon_abort = 1'b0; mon_t0 = cyc;
        for (int i = 0; i < 10; i++) begin
          mon_bits[i] = tx;
          for (int k = 1; k < CPB; k++) begin
            @(negedge clk);
            if (rst) mon_abort = 1'b1;
            if (tx !== mon_bits[i]) mon_ok = 1'b0;
          end
          if (i < 9) begin
            @(negedge clk);
            if (rst) mon_abort = 1'b1;
          end
        end
        if (!mon_abort) begin
          if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) mon_ok = 1'b0;
          check("char_framing", {31'd0, mon_ok}, 32'd1);
          rx_q.push_back(mon_bits[8:1]);
          rx_t.push_back(mon_t0);
          last_stop_cyc = cyc;
        end
      end
    end
  end

  // ---------------- driver: one full frame ----------------
  task automatic run_frame(input bit mid_pulse, input bit done_pulse);
    int budget, t_start, gap, max_gap;
    rx_q.delete(); rx_t.delete();
    build_expected();
    @(negedge clk); start = 1'b1; t_start = cyc;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    budget = 0;
    while (done !== 1'b1 && budget < 6000) begin
      @(negedge clk);
      budget++;
      start = (mid_pulse && budget == 1500);
    end
    start = 1'b0;
    if (budget >= 6000) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("done_after_stop", cyc - last_stop_cyc, 32'd2);
      check("busy_low_at_done", {31'd0, busy}, 32'd0);
    end
    if (rx_t.size() > 0)
      check("first_start_latency", {31'd0, (rx_t[0] - t_start) <= RL + 2}, 32'd1);
    if (done_pulse) start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    repeat (20 + 12 * CPB) @(negedge clk);
    check("busy_stays_low", {31'd0, busy}, 32'd0);
    check("frame_length", rx_q.size(), 32'd80);
    for (int i = 0; i < 80 && i < rx_q.size(); i++)
      check($sformatf("char%0d", i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    max_gap = 0;
    for (int i = 1; i < rx_t.size(); i++) begin
      gap = rx_t[i] - rx_t[i-1] - 10 * CPB;
      if (gap > max_gap) max_gap = gap;
    end
    check("max_char_gap", {31'd0, max_gap <= RL + 2}, 32'd1);
  endtask

  // ---------------- cell mapping table ----------------
  typedef struct { logic [1:0] d; logic w; logic [7:0] c; } vec_t;
  vec_t tbl [8];

  initial begin
    int budget;
    string s;
    rst = 1'b1; start = 1'b0;
    clear_board();
    tbl[0] = '{2'b00, 1'b0, 8'h2E}; tbl[1] = '{2'b00, 1'b1, 8'h2E};
    tbl[2] = '{2'b01, 1'b0, 8'h58}; tbl[3] = '{2'b01, 1'b1, 8'h78};
    tbl[4] = '{2'b10, 1'b0, 8'h4F}; tbl[5] = '{2'b10, 1'b1, 8'h6F};
    tbl[6] = '{2'b11, 1'b0, 8'h3F}; tbl[7] = '{2'b11, 1'b1, 8'h3F};

    repeat (3) @(negedge clk);
    check("rst_read_row", {29'd0, read_row}, 32'd7);
    check("rst_read_col", {29'd0, read_col}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tx", {31'd0, tx}, 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_tx", {31'd0, tx}, 32'd1);

    // Empty board.
    run_frame(1'b0, 1'b0);
    if (rx_q.size() == 80) begin
      check("empty_cr", {24'd0, rx_q[8]}, 32'h0D);
      check("empty_lf_last", {24'd0, rx_q[79]}, 32'h0A);
    end

    // Table: record i placed at row 7, col i, so it is frame character i.
    clear_board();
    for (int i = 0; i < 8; i++) begin
      cell_m[7][i] = tbl[i].d;
      win_m[7][i]  = tbl[i].w;
    end
    run_frame(1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      if (rx_q.size() > i) check($sformatf("tbl%0d", i), {24'd0, rx_q[i]}, {24'd0, tbl[i].c});

    // p1 at (r0,c3), p2 at (r1,c3): lines 7 and 8.
    clear_board();
    cell_m[0][3] = 2'b01; cell_m[1][3] = 2'b10;
    run_frame(1'b0, 1'b0);
    s = "...O....\r\n";
    for (int i = 0; i < 10; i++)
      if (rx_q.size() == 80) check("line7", {24'd0, rx_q[60+i]}, {24'd0, s[i]});
    s = "...X....\r\n";
    for (int i = 0; i < 10; i++)
      if (rx_q.size() == 80) check("line8", {24'd0, rx_q[70+i]}, {24'd0, s[i]});

    // Winning vertical at c0, rows 0..3, plus a non-winning O.
    clear_board();
    for (int r = 0; r < 4; r++) begin cell_m[r][0] = 2'b01; win_m[r][0] = 1'b1; end
    cell_m[0][1] = 2'b10;
    run_frame(1'b0, 1'b0);
    if (rx_q.size() == 80) begin
      for (int k = 5; k <= 8; k++) check("win_line_start", {24'd0, rx_q[(k-1)*10]}, 32'h78);
      check("nonwin_O", {24'd0, rx_q[71]}, 32'h4F);
    end

    // Random boards.
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          cell_m[r][c] = 2'($urandom_range(0, 3));
          win_m[r][c]  = 1'($urandom_range(0, 1));
        end
      run_frame(1'b0, 1'b0);
    end

    // start re-pulsed mid-frame and in the done cycle: both are ignored.
    run_frame(1'b1, 1'b1);
    run_frame(1'b0, 1'b0);

    // Reset during bit 5 of character 20.
    rx_q.delete(); rx_t.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    budget = 0;
    while (rx_q.size() < 20 && budget < 4000) begin @(negedge clk); budget++; end
    while (tx !== 1'b0 && budget < 4100) begin @(negedge clk); budget++; end
    check("reach_char20", {31'd0, budget < 4100}, 32'd1);
    repeat (5 * CPB + 1) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_row", {29'd0, read_row}, 32'd7);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_tx", {31'd0, tx}, 32'd1);
    run_frame(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
